// File: rtl/audio_serializer.sv
// audio_serializer: parallel-to-serial converter for the audio output path.
// Loads a DATA_WIDTH-bit sample and shifts it out MSB-first, holding each bit
// for CLK_DIV clocks. While enable stays high, words stream back-to-back with
// no gap between them.
module audio_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CLK_DIV    = 50
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  done,
  output logic                  audio_data,
  output logic                  audio_enable
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic                    done_q, done_d;
  logic                    audio_enable_q, audio_enable_d;

  // The serial bit is the MSB of the shift register. The register is cleared
  // whenever the block is idle, so audio_data is 0 outside a word.
  assign audio_data   = shift_q[DATA_WIDTH-1];
  assign audio_enable = audio_enable_q;
  assign done         = done_q;

  // Next-state logic: bit timing, word boundaries, load and reload of samples.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    div_cnt_d      = div_cnt_q;
    done_d         = 1'b0;
    audio_enable_d = audio_enable_q;

    unique case (state_q)
      ST_IDLE: begin
        shift_d        = '0;
        audio_enable_d = 1'b0;
        bit_cnt_d      = '0;
        div_cnt_d      = '0;
        if (enable) begin
          state_d        = ST_SHIFT;
          shift_d        = data_in;
          audio_enable_d = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            // Word boundary: pulse done, then reload or stop.
            done_d    = 1'b1;
            bit_cnt_d = '0;
            if (enable) begin
              shift_d        = data_in;
              audio_enable_d = 1'b1;
            end else begin
              state_d        = ST_IDLE;
              shift_d        = '0;
              audio_enable_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d        = ST_IDLE;
        shift_d        = '0;
        bit_cnt_d      = '0;
        div_cnt_d      = '0;
        audio_enable_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      div_cnt_q      <= '0;
      done_q         <= 1'b0;
      audio_enable_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      div_cnt_q      <= div_cnt_d;
      done_q         <= done_d;
      audio_enable_q <= audio_enable_d;
    end
  end

endmodule

// File: tb/tb_audio_serializer.sv
// tb_audio_serializer: directed bench for audio_serializer with CLK_DIV=4
// (main instance) and CLK_DIV=1 (second instance), both 16-bit words.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_audio_serializer;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [15:0] data_in;
  logic        done;
  logic        audio_data;
  logic        audio_enable;

  logic        enable1;
  logic [15:0] data_in1;
  logic        done1;
  logic        audio_data1;
  logic        audio_enable1;

  int total;
  int bad;

  audio_serializer #(.DATA_WIDTH(16), .CLK_DIV(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .data_in      (data_in),
    .done         (done),
    .audio_data   (audio_data),
    .audio_enable (audio_enable)
  );

  audio_serializer #(.DATA_WIDTH(16), .CLK_DIV(1)) dut1 (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable1),
    .data_in      (data_in1),
    .done         (done1),
    .audio_data   (audio_data1),
    .audio_enable (audio_enable1)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count one comparison and report it if it disagrees.
  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", tag, $time, obs, exp);
    end
  endtask

  // Expected bit of word w at bit position idx (0 = MSB).
  function automatic logic word_bit(input logic [15:0] w, input int idx);
    logic [15:0] t;
    t = w >> (15 - idx);
    return t[0];
  endfunction

  initial begin
    logic [15:0] w;
    total    = 0;
    bad      = 0;

    // Reset held with enable high and all-ones data: outputs stay 0.
    reset_n  = 1'b0;
    enable   = 1'b1;
    data_in  = 16'hFFFF;
    enable1  = 1'b1;
    data_in1 = 16'hFFFF;
    repeat (3) begin
      @(negedge clock);
      chk("rst_done", done, 1'b0);
      chk("rst_data", audio_data, 1'b0);
      chk("rst_aen", audio_enable, 1'b0);
      chk("rst_done1", done1, 1'b0);
      chk("rst_data1", audio_data1, 1'b0);
      chk("rst_aen1", audio_enable1, 1'b0);
    end
    enable   = 1'b0;
    enable1  = 1'b0;
    reset_n  = 1'b1;
    @(negedge clock);
    chk("idle_done", done, 1'b0);
    chk("idle_data", audio_data, 1'b0);
    chk("idle_aen", audio_enable, 1'b0);

    // Single word 0x8001, enable dropped right after the load.
    data_in = 16'h8001;
    enable  = 1'b1;
    for (int k = 0; k <= 65; k++) begin
      @(negedge clock);
      if (k == 0) enable = 1'b0;
      chk("one_data", audio_data, (k < 64) ? word_bit(16'h8001, k / 4) : 1'b0);
      chk("one_done", done, k == 64);
      chk("one_aen", audio_enable, k < 64);
    end

    // Streaming 0xA5A5 then 0x0F0F with no gap; enable dropped mid second word.
    data_in = 16'hA5A5;
    enable  = 1'b1;
    for (int k = 0; k <= 129; k++) begin
      @(negedge clock);
      if (k == 1) data_in = 16'h0F0F;
      if (k == 70) enable = 1'b0;
      w = (k < 64) ? 16'hA5A5 : 16'h0F0F;
      chk("str_data", audio_data, (k < 128) ? word_bit(w, (k % 64) / 4) : 1'b0);
      chk("str_done", done, (k == 64) || (k == 128));
      chk("str_aen", audio_enable, k < 128);
    end

    // Mid-word data change and enable drop must not disturb the current word.
    data_in = 16'hFFFF;
    enable  = 1'b1;
    for (int k = 0; k <= 65; k++) begin
      @(negedge clock);
      if (k == 20) begin
        data_in = 16'h0000;
        enable  = 1'b0;
      end
      chk("mid_data", audio_data, k < 64);
      chk("mid_done", done, k == 64);
      chk("mid_aen", audio_enable, k < 64);
    end

    // Reset mid-word: outputs clear immediately; fresh load after release.
    data_in = 16'h1234;
    enable  = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clock);
      chk("pre_data", audio_data, word_bit(16'h1234, k / 4));
      chk("pre_aen", audio_enable, 1'b1);
    end
    reset_n = 1'b0;
    #1;
    chk("arst_data", audio_data, 1'b0);
    chk("arst_aen", audio_enable, 1'b0);
    chk("arst_done", done, 1'b0);
    data_in = 16'hC003;
    @(negedge clock);
    chk("arst_hold_data", audio_data, 1'b0);
    chk("arst_hold_aen", audio_enable, 1'b0);
    reset_n = 1'b1;
    for (int k = 0; k <= 65; k++) begin
      @(negedge clock);
      if (k == 0) enable = 1'b0;
      chk("post_data", audio_data, (k < 64) ? word_bit(16'hC003, k / 4) : 1'b0);
      chk("post_done", done, k == 64);
      chk("post_aen", audio_enable, k < 64);
    end

    // CLK_DIV=1: one bit per cycle, done every 16 cycles, three words.
    data_in1 = 16'h8001;
    enable1  = 1'b1;
    for (int k = 0; k <= 49; k++) begin
      @(negedge clock);
      if (k == 40) enable1 = 1'b0;
      chk("d1_data", audio_data1, (k < 48) ? word_bit(16'h8001, k % 16) : 1'b0);
      chk("d1_done", done1, (k == 16) || (k == 32) || (k == 48));
      chk("d1_aen", audio_enable1, k < 48);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_serializer.md
Name: audio_serializer

Overview:
- Parallel-to-serial converter for the audio output path.
- Captures a DATA_WIDTH-bit sample from data_in and shifts it out MSB-first on audio_data, one bit per CLK_DIV clock cycles.
- Drives audio_enable (amplifier enable) while a word is being sent and pulses done at each word boundary.
- Sits between the sample source (tone/timer logic) and the board audio pin; back-to-back words stream with no gap while enable stays high.

Parameters:
- DATA_WIDTH, 16, bits per sample word; must be >= 2.
- CLK_DIV, 50, clock cycles each bit is held on audio_data; must be >= 1.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  request to stream; sampled on rising edges.
- data_in  input  DATA_WIDTH  sample word; sampled only at word load.
- done  output  1  registered one-cycle pulse at the end of each word.
- audio_data  output  1  registered serial bit, MSB first.
- audio_enable  output  1  registered high while a word is being shifted.

Behaviour:
- Reset (reset_n=0, asynchronous) sets the following, and holds them while reset_n=0:
  - state=IDLE; shift register, bit counter and divider counter all 0.
  - audio_data=0, audio_enable=0, done=0.
- IDLE:
  - Outputs are 0.
  - On an edge with enable=1: load shift_reg<=data_in, set audio_data<=data_in[DATA_WIDTH-1], set audio_enable<=1, clear div_cnt and bit_cnt, go to SHIFT.
  - The load edge is T0.
- SHIFT: div_cnt increments each cycle. When div_cnt==CLK_DIV-1:
  - div_cnt<=0.
  - If bit_cnt<DATA_WIDTH-1: bit_cnt++, shift left by one, audio_data<=next bit.
  - If bit_cnt==DATA_WIDTH-1 (word complete):
    - done<=1 for exactly one cycle.
    - If enable=1: reload from data_in in the same edge (new MSB on audio_data, bit_cnt<=0, stay in SHIFT, audio_enable stays 1). No idle cycle between words.
    - If enable=0: go to IDLE, audio_data<=0, audio_enable<=0.
- Timing: bit i (0 = MSB) is on audio_data during cycles T0+i*CLK_DIV through T0+(i+1)*CLK_DIV-1.
  - Word period is exactly DATA_WIDTH*CLK_DIV cycles.
  - done is high in the cycle starting at T0+DATA_WIDTH*CLK_DIV.
- done is 0 at all other times, including in IDLE.
- enable deasserted mid-word: the current word completes fully (no truncation); return to IDLE at the word boundary.
- data_in changes mid-word are ignored; data_in is captured only at load/reload edges.
- enable re-asserted in IDLE: the load happens on the next edge.
- CLK_DIV=1: audio_data changes every cycle; done occurs every DATA_WIDTH cycles.
- Reset asserted mid-word: immediate return to reset values; the partial word is discarded.
- Counter widths: div_cnt is $clog2(CLK_DIV)+1 bits; bit_cnt is $clog2(DATA_WIDTH)+1 bits. No wrap beyond the terminal counts.

Test Plan:
- Reset: drive reset_n=0 with enable=1 and data_in=0xFFFF -> done=0, audio_data=0, audio_enable=0 throughout reset.
- Single word, CLK_DIV=4, data_in=0x8001, enable=1 for one word then 0:
  - audio_data=1 for cycles 0-3, 0 for cycles 4-59, 1 for cycles 60-63.
  - done pulses once at cycle 64.
  - audio_enable falls at cycle 64.
- Streaming, CLK_DIV=4, enable held 1, data_in=0xA5A5 then 0x0F0F:
  - Bit pattern 1010010110100101 is followed immediately by 0000111100001111.
  - done pulses at cycles 64 and 128.
  - audio_enable is never low.
- Mid-word changes: change data_in to 0x0000 and drop enable at cycle 20 while sending 0xFFFF -> audio_data stays 1 through cycle 63; done pulses at cycle 64, then IDLE.
- Reset mid-word: pulse reset_n low at cycle 30 -> outputs are 0 immediately; with enable=1, a fresh load occurs on the first edge after release.
- CLK_DIV=1, data_in=0x8001 streaming -> one bit per cycle; done pulses every 16 cycles.
